// File: rtl/mem_issue_pkg.sv
// Shared types and sizing helpers for the memory-issue stage and its tracking FIFO.
package mem_issue_pkg;

   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned PAYLOAD_W = 64;
   localparam int unsigned STRB_W    = DATA_W / 8;
   // Outstanding/drain counters are wider than the FIFO: repeated flushes can stack in-flight requests.
   localparam int unsigned OUTST_W   = 8;

   localparam logic [2:0] UNCACHED_SEG = 3'b101;

   typedef struct packed {
      logic [PAYLOAD_W-1:0] payload;
      logic [DATA_W-1:0]    rdata;
      logic                 ex;
      logic                 need_resp;
      logic                 done;
   } entry_t;

   typedef struct packed {
      logic [PAYLOAD_W-1:0] payload;
      logic [DATA_W-1:0]    rdata;
      logic                 ex;
   } head_t;

   typedef struct packed {
      logic [PAYLOAD_W-1:0] payload;
      logic [ADDR_W-1:0]    paddr;
      logic [DATA_W-1:0]    wdata;
      logic [STRB_W-1:0]    wstrb;
      logic                 load;
      logic                 store;
      logic                 ex;
   } stage_t;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/mem_issue_stage_if.sv
// Upstream, DCache and downstream signals of the memory-issue stage.
interface mem_issue_stage_if;
   import mem_issue_pkg::*;

   logic                 in_valid;
   logic                 in_allowin;
   logic [PAYLOAD_W-1:0] in_payload;
   logic                 in_load;
   logic                 in_store;
   logic                 in_ex;
   logic [ADDR_W-1:0]    in_paddr;
   logic [STRB_W-1:0]    in_wstrb;
   logic [DATA_W-1:0]    in_wdata;

   logic                 req_valid;
   logic                 req_op;
   logic [ADDR_W-1:0]    req_addr;
   logic [STRB_W-1:0]    req_wstrb;
   logic [DATA_W-1:0]    req_wdata;
   logic                 req_uncached;
   logic                 req_addr_ok;
   logic                 data_ok;
   logic [DATA_W-1:0]    data_rdata;

   logic                 out_valid;
   logic                 out_allowin;
   logic [PAYLOAD_W-1:0] out_payload;
   logic [DATA_W-1:0]    out_rdata;
   logic                 out_ex;

   modport slave (
      input  in_valid, in_payload, in_load, in_store, in_ex, in_paddr, in_wstrb, in_wdata,
      output in_allowin,
      output req_valid, req_op, req_addr, req_wstrb, req_wdata, req_uncached,
      input  req_addr_ok, data_ok, data_rdata,
      output out_valid, out_payload, out_rdata, out_ex,
      input  out_allowin
   );

   modport master (
      output in_valid, in_payload, in_load, in_store, in_ex, in_paddr, in_wstrb, in_wdata,
      input  in_allowin,
      input  req_valid, req_op, req_addr, req_wstrb, req_wdata, req_uncached,
      output req_addr_ok, data_ok, data_rdata,
      input  out_valid, out_payload, out_rdata, out_ex,
      output out_allowin
   );

endinterface

// File: rtl/inorder_track_fifo.sv
// Circular buffer of in-flight instructions; responses complete the oldest pending entry.
module inorder_track_fifo
   import mem_issue_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              push,
   input  entry_t            push_entry,
   input  logic              pop,
   input  logic              mark,
   input  logic [DATA_W-1:0] mark_rdata,
   output head_t             head,
   output logic              head_done,
   output logic              full,
   output logic              empty
);

   localparam int unsigned PTR_W = ptr_width(DEPTH);
   localparam int unsigned CNT_W = cnt_width(DEPTH);
   localparam int unsigned SUM_W = PTR_W + 1;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count;
   logic [DEPTH-1:0]   mark_sel;
   logic [SUM_W-1:0]   sum;
   logic               found;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign head_done = !empty && mem[rd_ptr].done;
   assign head      = '{payload: mem[rd_ptr].payload, rdata: mem[rd_ptr].rdata, ex: mem[rd_ptr].ex};

   // Walk from the head to find the oldest entry still waiting on a response.
   always_comb begin
      mark_sel = '0;
      found    = 1'b0;
      sum      = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         sum = SUM_W'(rd_ptr) + SUM_W'(i);
         if (sum >= SUM_W'(DEPTH)) sum = sum - SUM_W'(DEPTH);
         if (mark && !found && (CNT_W'(i) < count) &&
             !mem[sum[PTR_W-1:0]].done && mem[sum[PTR_W-1:0]].need_resp) begin
            mark_sel[sum[PTR_W-1:0]] = 1'b1;
            found                    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (push && (wr_ptr == PTR_W'(i))) begin
            mem[i] <= push_entry;
         end else if (mark_sel[i]) begin
            mem[i].done  <= 1'b1;
            mem[i].rdata <= mark_rdata;
         end
      end
   end

endmodule

// File: rtl/mem_issue_stage.sv
// Non-blocking memory-issue stage: one staged instruction, split-handshake DCache issue,
// in-order tracking of up to OUT_DEPTH in-flight instructions, flush with response drain.
module mem_issue_stage
   import mem_issue_pkg::*;
#(
   parameter int unsigned OUT_DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   mem_issue_stage_if.slave   bus
);

   stage_t               stg;
   logic                 stg_valid;
   logic                 mem_op;
   logic                 full;
   logic                 fifo_empty;
   logic                 head_done;
   logic                 hs;
   logic                 push;
   logic                 pop;
   logic                 dresp;
   logic                 resp;
   head_t                head;
   entry_t               push_entry;
   logic [OUTST_W-1:0]   outstanding;
   logic [OUTST_W-1:0]   drain_cnt;

   assign mem_op = (stg.load | stg.store) & ~stg.ex;

   assign bus.req_valid    = stg_valid & mem_op & ~full & ~flush;
   assign bus.req_op       = stg.store;
   assign bus.req_addr     = stg.paddr;
   assign bus.req_wstrb    = stg.store ? stg.wstrb : '0;
   assign bus.req_wdata    = stg.wdata;
   assign bus.req_uncached = (stg.paddr[ADDR_W-1 -: 3] == UNCACHED_SEG);

   assign hs   = bus.req_valid & bus.req_addr_ok;
   // Non-memory or excepted instructions retire into the FIFO already complete.
   assign push = stg_valid & ~full & ~flush & (mem_op ? bus.req_addr_ok : 1'b1);
   assign bus.in_allowin = ~stg_valid | push;

   assign push_entry = '{payload: stg.payload, rdata: '0, ex: stg.ex,
                         need_resp: mem_op, done: ~mem_op};

   // Responses with nothing outstanding are protocol errors and are ignored.
   assign dresp = bus.data_ok & (outstanding != '0);
   assign resp  = dresp & (drain_cnt == '0) & ~flush;

   assign bus.out_valid   = ~fifo_empty & head_done;
   assign pop             = bus.out_valid & bus.out_allowin;
   assign bus.out_payload = bus.out_valid ? head.payload : '0;
   assign bus.out_rdata   = bus.out_valid ? head.rdata   : '0;
   assign bus.out_ex      = bus.out_valid & head.ex;

   always_ff @(posedge clk) begin
      if (reset) begin
         stg_valid <= 1'b0;
         stg       <= '0;
      end else if (flush) begin
         stg_valid <= 1'b0;
      end else if (bus.in_valid && bus.in_allowin) begin
         stg_valid <= 1'b1;
         stg       <= '{payload: bus.in_payload, paddr: bus.in_paddr, wdata: bus.in_wdata,
                        wstrb: bus.in_wstrb, load: bus.in_load, store: bus.in_store,
                        ex: bus.in_ex};
      end else if (push) begin
         stg_valid <= 1'b0;
      end
   end

   // Responses still owed to flushed requests are counted off before new ones are accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         outstanding <= '0;
         drain_cnt   <= '0;
      end else begin
         outstanding <= outstanding + OUTST_W'(hs) - OUTST_W'(dresp);
         if (flush)
            drain_cnt <= outstanding - OUTST_W'(dresp);
         else if (dresp && (drain_cnt != '0))
            drain_cnt <= drain_cnt - OUTST_W'(1);
      end
   end

   inorder_track_fifo #(.DEPTH(OUT_DEPTH)) u_track (
      .clk        (clk),
      .reset      (reset),
      .clear      (flush),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .mark       (resp),
      .mark_rdata (bus.data_rdata),
      .head       (head),
      .head_done  (head_done),
      .full       (full),
      .empty      (fifo_empty)
   );

endmodule

// File: tb/tb_mem_issue_stage.sv
// Directed bench for mem_issue_stage: cycle-exact checks plus an in-order output scoreboard.
module tb_mem_issue_stage;
   import mem_issue_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   int   n_vec = 0;
   int   n_err = 0;

   typedef struct {
      logic [63:0] payload;
      logic [31:0] rdata;
      logic        ex;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   mem_issue_stage_if bus ();

   mem_issue_stage #(.OUT_DEPTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drive_in(input logic [63:0] pl, input logic ld, input logic st, input logic ex,
                           input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd);
      bus.in_valid   = 1'b1;
      bus.in_payload = pl;
      bus.in_load    = ld;
      bus.in_store   = st;
      bus.in_ex      = ex;
      bus.in_paddr   = addr;
      bus.in_wstrb   = strb;
      bus.in_wdata   = wd;
   endtask

   // Load accepted at N, addr_ok at N+1, data_ok at N+2, completion visible at N+3.
   task automatic single_load(input logic [63:0] pl, input logic [31:0] addr, input logic [31:0] rd);
      cyc();
      drive_in(pl, 1'b1, 1'b0, 1'b0, addr, 4'hF, 32'h0);
      exp_q.push_back('{payload: pl, rdata: rd, ex: 1'b0});
      smp();
      check_eq("sl_allowin", 128'(bus.in_allowin), 128'd1);
      cyc();
      bus.in_valid    = 1'b0;
      bus.req_addr_ok = 1'b1;
      smp();
      check_eq("sl_req_valid", 128'(bus.req_valid), 128'd1);
      check_eq("sl_req_addr", 128'(bus.req_addr), 128'(addr));
      check_eq("sl_req_op", 128'(bus.req_op), 128'd0);
      check_eq("sl_req_wstrb", 128'(bus.req_wstrb), 128'd0);
      check_eq("sl_req_uncached", 128'(bus.req_uncached), 128'd0);
      cyc();
      bus.req_addr_ok = 1'b0;
      bus.data_ok     = 1'b1;
      bus.data_rdata  = rd;
      smp();
      check_eq("sl_out_early", 128'(bus.out_valid), 128'd0);
      cyc();
      bus.data_ok = 1'b0;
      smp();
      check_eq("sl_out_valid", 128'(bus.out_valid), 128'd1);
      cyc();
   endtask

   // Scoreboard: every completed instruction must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_allowin) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 128'(exp_q.size()), 128'd1);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("out_payload", 128'(bus.out_payload), 128'(mon_e.payload));
            check_eq("out_rdata", 128'(bus.out_rdata), 128'(mon_e.rdata));
            check_eq("out_ex", 128'(bus.out_ex), 128'(mon_e.ex));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      bus.in_valid = 1'b0; bus.in_payload = '0; bus.in_load = 1'b0; bus.in_store = 1'b0;
      bus.in_ex = 1'b0; bus.in_paddr = '0; bus.in_wstrb = '0; bus.in_wdata = '0;
      bus.req_addr_ok = 1'b0; bus.data_ok = 1'b0; bus.data_rdata = '0;
      bus.out_allowin = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      smp();
      check_eq("rst_allowin", 128'(bus.in_allowin), 128'd1);
      check_eq("rst_req_valid", 128'(bus.req_valid), 128'd0);
      check_eq("rst_req_op", 128'(bus.req_op), 128'd0);
      check_eq("rst_req_addr", 128'(bus.req_addr), 128'd0);
      check_eq("rst_req_wstrb", 128'(bus.req_wstrb), 128'd0);
      check_eq("rst_req_wdata", 128'(bus.req_wdata), 128'd0);
      check_eq("rst_req_uncached", 128'(bus.req_uncached), 128'd0);
      check_eq("rst_out_valid", 128'(bus.out_valid), 128'd0);
      check_eq("rst_out_payload", 128'(bus.out_payload), 128'd0);
      check_eq("rst_out_rdata", 128'(bus.out_rdata), 128'd0);
      check_eq("rst_out_ex", 128'(bus.out_ex), 128'd0);

      // Single load
      single_load(64'h1111_0000_0000_0001, 32'h0000_1000, 32'hDEAD_BEEF);

      // Store to kseg1 with addr_ok delayed three cycles
      cyc();
      drive_in(64'h2222_0000_0000_0002, 1'b0, 1'b1, 1'b0, 32'hA000_0010, 4'b0011, 32'h1234_5678);
      exp_q.push_back('{payload: 64'h2222_0000_0000_0002, rdata: 32'h0, ex: 1'b0});
      cyc();
      bus.in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.req_addr_ok = (k == 3);
         smp();
         check_eq("st_req_valid", 128'(bus.req_valid), 128'd1);
         check_eq("st_req_op", 128'(bus.req_op), 128'd1);
         check_eq("st_req_addr", 128'(bus.req_addr), 128'hA000_0010);
         check_eq("st_req_wstrb", 128'(bus.req_wstrb), 128'h3);
         check_eq("st_req_wdata", 128'(bus.req_wdata), 128'h1234_5678);
         check_eq("st_req_uncached", 128'(bus.req_uncached), 128'd1);
         check_eq("st_allowin", 128'(bus.in_allowin), 128'(k == 3));
         cyc();
      end
      bus.req_addr_ok = 1'b0;
      bus.data_ok     = 1'b1;
      bus.data_rdata  = 32'h0;
      smp();
      check_eq("st_req_after_hs", 128'(bus.req_valid), 128'd0);
      cyc();
      bus.data_ok = 1'b0;
      smp();
      check_eq("st_out_valid", 128'(bus.out_valid), 128'd1);
      cyc();

      // Three loads against a depth-2 tracker
      cyc();
      drive_in(64'hA, 1'b1, 1'b0, 1'b0, 32'h100, 4'hF, 32'h0);
      exp_q.push_back('{payload: 64'hA, rdata: 32'hAAAA_0001, ex: 1'b0});
      cyc();
      drive_in(64'hB, 1'b1, 1'b0, 1'b0, 32'h104, 4'hF, 32'h0);
      exp_q.push_back('{payload: 64'hB, rdata: 32'hBBBB_0002, ex: 1'b0});
      bus.req_addr_ok = 1'b1;
      smp();
      check_eq("q3_req_a", 128'(bus.req_addr), 128'h100);
      cyc();
      drive_in(64'hC, 1'b1, 1'b0, 1'b0, 32'h108, 4'hF, 32'h0);
      exp_q.push_back('{payload: 64'hC, rdata: 32'hCCCC_0003, ex: 1'b0});
      smp();
      check_eq("q3_req_b_valid", 128'(bus.req_valid), 128'd1);
      check_eq("q3_req_b", 128'(bus.req_addr), 128'h104);
      cyc();
      bus.in_valid = 1'b0;
      smp();
      check_eq("q3_full_req", 128'(bus.req_valid), 128'd0);
      check_eq("q3_full_allowin", 128'(bus.in_allowin), 128'd0);
      cyc();
      bus.req_addr_ok = 1'b0;
      bus.data_ok = 1'b1; bus.data_rdata = 32'hAAAA_0001;
      smp();
      check_eq("q3_full_req2", 128'(bus.req_valid), 128'd0);
      cyc();
      bus.data_rdata = 32'hBBBB_0002;
      smp();
      check_eq("q3_out_a", 128'(bus.out_valid), 128'd1);
      check_eq("q3_pop_no_free", 128'(bus.req_valid), 128'd0);
      cyc();
      bus.data_ok = 1'b0;
      bus.req_addr_ok = 1'b1;
      smp();
      check_eq("q3_out_b", 128'(bus.out_valid), 128'd1);
      check_eq("q3_req_c_valid", 128'(bus.req_valid), 128'd1);
      check_eq("q3_req_c", 128'(bus.req_addr), 128'h108);
      cyc();
      bus.req_addr_ok = 1'b0;
      bus.data_ok = 1'b1; bus.data_rdata = 32'hCCCC_0003;
      smp();
      check_eq("q3_req_idle", 128'(bus.req_valid), 128'd0);
      cyc();
      bus.data_ok = 1'b0;
      smp();
      check_eq("q3_out_c", 128'(bus.out_valid), 128'd1);
      cyc();

      // Flush with two outstanding, then a new load must take the third response
      cyc();
      drive_in(64'hD, 1'b1, 1'b0, 1'b0, 32'h200, 4'hF, 32'h0);
      cyc();
      drive_in(64'hE, 1'b1, 1'b0, 1'b0, 32'h204, 4'hF, 32'h0);
      bus.req_addr_ok = 1'b1;
      cyc();
      bus.in_valid = 1'b0;
      cyc();
      bus.req_addr_ok = 1'b0;
      flush = 1'b1;
      smp();
      check_eq("fl_req_gated", 128'(bus.req_valid), 128'd0);
      cyc();
      flush = 1'b0;
      drive_in(64'hF, 1'b1, 1'b0, 1'b0, 32'h300, 4'hF, 32'h0);
      exp_q.push_back('{payload: 64'hF, rdata: 32'hF00D_F00D, ex: 1'b0});
      cyc();
      bus.in_valid = 1'b0;
      bus.req_addr_ok = 1'b1;
      smp();
      check_eq("fl_new_req", 128'(bus.req_valid), 128'd1);
      check_eq("fl_new_addr", 128'(bus.req_addr), 128'h300);
      cyc();
      bus.req_addr_ok = 1'b0;
      bus.data_ok = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.data_rdata = (k == 2) ? 32'hF00D_F00D : 32'hBAD0_0000 + 32'(k);
         smp();
         check_eq("fl_drain_out", 128'(bus.out_valid), 128'd0);
         cyc();
      end
      bus.data_ok = 1'b0;
      smp();
      check_eq("fl_out_valid", 128'(bus.out_valid), 128'd1);
      cyc();

      // Excepted store: no request, completes two cycles after accept
      cyc();
      drive_in(64'h5555, 1'b0, 1'b1, 1'b1, 32'hA000_0020, 4'hF, 32'h0);
      exp_q.push_back('{payload: 64'h5555, rdata: 32'h0, ex: 1'b1});
      cyc();
      bus.in_valid = 1'b0;
      smp();
      check_eq("ex_req_n1", 128'(bus.req_valid), 128'd0);
      check_eq("ex_out_n1", 128'(bus.out_valid), 128'd0);
      cyc();
      smp();
      check_eq("ex_req_n2", 128'(bus.req_valid), 128'd0);
      check_eq("ex_out_n2", 128'(bus.out_valid), 128'd1);
      cyc();

      // Flush coinciding with the only response: nothing left to drain
      cyc();
      drive_in(64'h6666, 1'b1, 1'b0, 1'b0, 32'h400, 4'hF, 32'h0);
      cyc();
      bus.in_valid = 1'b0;
      bus.req_addr_ok = 1'b1;
      cyc();
      bus.req_addr_ok = 1'b0;
      flush = 1'b1;
      bus.data_ok = 1'b1; bus.data_rdata = 32'hBAD0_0003;
      cyc();
      flush = 1'b0;
      bus.data_ok = 1'b0;
      single_load(64'h7777, 32'h404, 32'h600D_CAFE);

      // Reset overrides flush and discards drain state
      cyc();
      drive_in(64'h8888, 1'b1, 1'b0, 1'b0, 32'h500, 4'hF, 32'h0);
      cyc();
      drive_in(64'h9999, 1'b1, 1'b0, 1'b0, 32'h504, 4'hF, 32'h0);
      bus.req_addr_ok = 1'b1;
      cyc();
      bus.in_valid = 1'b0;
      cyc();
      bus.req_addr_ok = 1'b0;
      reset = 1'b1;
      flush = 1'b1;
      cyc();
      reset = 1'b0;
      flush = 1'b0;
      smp();
      check_eq("rs_allowin", 128'(bus.in_allowin), 128'd1);
      check_eq("rs_out_valid", 128'(bus.out_valid), 128'd0);
      check_eq("rs_req_valid", 128'(bus.req_valid), 128'd0);
      single_load(64'hAAAA, 32'h508, 32'h1212_1212);

      // Stray response with nothing outstanding is ignored
      cyc();
      bus.data_ok = 1'b1; bus.data_rdata = 32'hEEEE_EEEE;
      cyc();
      bus.data_ok = 1'b0;
      smp();
      check_eq("stray_out", 128'(bus.out_valid), 128'd0);
      single_load(64'hBBBB, 32'h50C, 32'h3434_3434);

      repeat (3) cyc();
      check_eq("sb_left", 128'(exp_q.size()), 128'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_issue_stage.md
# mem_issue_stage

Non-blocking memory-issue pipeline stage between EXE and the writeback-side MEM stage. It holds one instruction, issues its DCache request with the split addr_ok/data_ok handshake, and frees itself as soon as the request is accepted. Up to OUT_DEPTH instructions stay in flight in an in-order tracking FIFO. It generalises the single-outstanding M1-stage request logic: multiple outstanding requests, in-order retirement, and a flush that drains stale responses without stalling new issue.

## Interface
- ADDR_W, 32, physical address width
- DATA_W, 32, load/store data width
- PAYLOAD_W, 64, opaque sideband bus (pc, dest, controls) carried with each instruction
- OUT_DEPTH, 2, maximum tracked instructions (≥1); power of two not required
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream instruction valid
- in_allowin  out  1  stage can accept upstream instruction this cycle
- in_payload  in  PAYLOAD_W  sideband
- in_load, in_store  in  1 each  memory op kind (mutually exclusive)
- in_ex  in  1  instruction already carries an exception
- in_paddr  in  ADDR_W  translated address
- in_wstrb  in  DATA_W/8  store byte enables
- in_wdata  in  DATA_W  store data
- flush  in  1  pipeline flush (exception/eret)
- req_valid  out  1  DCache request
- req_op  out  1  1 = store
- req_addr  out  ADDR_W  request address
- req_wstrb  out  DATA_W/8  zero for loads
- req_wdata  out  DATA_W  store data
- req_uncached  out  1  in_paddr[ADDR_W-1:ADDR_W-3]==3'b101 (kseg1 window)
- req_addr_ok  in  1  request accepted
- data_ok  in  1  in-order response
- data_rdata  in  DATA_W  load data
- out_valid  out  1  head instruction complete
- out_allowin  in  1  downstream accepts
- out_payload  out  PAYLOAD_W; out_rdata  out  DATA_W; out_ex  out  1

## Operation
- Stage register: loaded on in_valid & in_allowin. in_allowin = !stg_valid | push.
- Mem op = (in_load|in_store) & !in_ex. req_valid = stg_valid & mem op & !full & !flush; req_* are driven from the stage register.
- Push to tracking FIFO: mem op on req_valid & req_addr_ok, entry done=0. Non-mem or excepted instruction when !full, entry done=1, no request.
- Response: data_ok with drain_cnt==0 sets done and captures rdata in the oldest entry with done=0 and need_resp=1.
- Output: out_valid = head.done. Pop on out_valid & out_allowin.
- full = (count == OUT_DEPTH), using the registered count. A same-cycle pop does not free a slot for push.
- outstanding counter: +1 on request handshake, -1 on data_ok. Both in one cycle leaves it unchanged.
- Flush: clears the stage register, FIFO and count. drain_cnt <= outstanding − (data_ok ? 1 : 0). While drain_cnt>0, each data_ok decrements it and is dropped. New requests may issue during drain; ordering guarantees that later responses belong to them.
- flush and in_valid in the same cycle: the input is not loaded.
- data_ok with outstanding==0 and drain_cnt==0 is a protocol error; the block ignores it.

## Timing
- Reset: all outputs 0, except in_allowin=1. FIFO empty; outstanding=0; drain_cnt=0.
- Non-mem instruction: accepted cycle N, pushed N+1, out_valid N+2.
- Load: req_valid at N+1. With addr_ok at N+1 and data_ok at N+2, out_valid is at N+3 with out_rdata.
- req_valid is held, with stable req_*, until addr_ok or flush.
- Back-to-back issue rate: one request per cycle while !full.
- Reset mid-operation overrides flush and drops everything, including drain state.

## Structure
- Package mem_issue_pkg: entry struct {payload, rdata, ex, need_resp, done}, the UNCACHED_SEG constant (3'b101), and the pointer/count width function for OUT_DEPTH.
- Sub-module inorder_track_fifo: a circular buffer with push, pop, head, and "mark oldest pending done" ports. It has a clear input and separate wrap-around pointers.

## Test plan
- Single load to 0x0000_1000: addr_ok same cycle, data_ok 1 cycle later with 0xDEADBEEF -> out_valid 3 cycles after accept, out_rdata=0xDEADBEEF, req_uncached=0.
- Store to 0xA000_0010, wstrb 4'b0011, addr_ok delayed 3 cycles -> req_* stable for 4 cycles, req_op=1, req_uncached=1; in_allowin stays 0 until the handshake.
- OUT_DEPTH=2, three loads with data_ok withheld -> third req_valid=0 (full). Release two data_ok -> in-order out with the correct rdata. Then the third issues.
- Two loads outstanding, flush, then a new load issued -> first two data_ok are dropped (drain_cnt 2→0) and the third data_ok completes the new load.
- in_ex=1 store -> no req_valid, out_valid after 2 cycles with out_ex=1.
- flush in the same cycle as data_ok with one outstanding -> drain_cnt=0 and the next data_ok is accepted normally.
